cfg_bitstream_loader: RTL and testbench

- Upstream configuration controller for the switch-box/logic-block config chain.
- Accepts bitstream words over a valid/ready byte stream and serialises them, LSB first, onto prog_in with prog_en. Each chain element shifts {prog_in, reg[N-1:1]} on each enabled prog_clk edge.
- Loads exactly CHAIN_LEN bits per session, then reports done/err.

---
 rtl/cfg_bitstream_loader.sv | 188 ++++++++++++++++++
 tb/tb_cfg_bitstream_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_bitstream_loader.sv
// cfg_bitstream_loader: takes words over valid/ready and shifts them LSB first
// onto prog_in/prog_en, loading exactly CHAIN_LEN bits into the config chain.
// Optional: define CFG_LOADER_CRC_EN to check a CRC-16-CCITT trailer after the data.
module cfg_bitstream_loader #(
   parameter int unsigned CHAIN_LEN = 32,
   parameter int unsigned WORD_W    = 8,
   parameter int unsigned CNT_W     = 16
) (
   input  logic              prog_clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [WORD_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              prog_in,
   output logic              prog_en,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [CNT_W-1:0]  bit_cnt
);

   localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

`ifdef CFG_LOADER_CRC_EN
   localparam int unsigned CRC_WORDS = (16 + WORD_W - 1) / WORD_W;
   localparam int unsigned RX_W      = CRC_WORDS * WORD_W;
   localparam int unsigned CW_W      = $clog2(CRC_WORDS + 1);
   localparam logic [CW_W-1:0] LAST_CW = CW_W'(CRC_WORDS - 1);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SHIFT, S_DONE, S_CRC} state_t;

   logic [15:0]     crc_q, crc_d;
   logic [RX_W-1:0] rx_q, rx_d;
   logic [CW_W-1:0] cw_q, cw_d;

   // One CRC-16-CCITT step (poly 0x1021, MSB first) for a single data bit.
   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      logic fb;
      fb = c[15] ^ b;
      return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction
`else
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SHIFT, S_DONE} state_t;
`endif

   state_t            state_q, state_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_d;
   logic              prog_in_d, prog_en_d, din_ready_d, busy_d, done_d, err_d;

   // State and registered outputs.
   always_ff @(posedge prog_clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         word_q    <= '0;
         idx_q     <= '0;
         bit_cnt   <= '0;
         prog_in   <= 1'b0;
         prog_en   <= 1'b0;
         din_ready <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
`ifdef CFG_LOADER_CRC_EN
         crc_q     <= '0;
         rx_q      <= '0;
         cw_q      <= '0;
`endif
      end else begin
         state_q   <= state_d;
         word_q    <= word_d;
         idx_q     <= idx_d;
         bit_cnt   <= cnt_d;
         prog_in   <= prog_in_d;
         prog_en   <= prog_en_d;
         din_ready <= din_ready_d;
         busy      <= busy_d;
         done      <= done_d;
         err       <= err_d;
`ifdef CFG_LOADER_CRC_EN
         crc_q     <= crc_d;
         rx_q      <= rx_d;
         cw_q      <= cw_d;
`endif
      end
   end

   // Next state and next output values; abort wins over shift and handshake.
   always_comb begin
      state_d   = state_q;
      word_d    = word_q;
      idx_d     = idx_q;
      cnt_d     = bit_cnt;
      prog_in_d = prog_in;
      prog_en_d = 1'b0;
      done_d    = done;
      err_d     = err;
`ifdef CFG_LOADER_CRC_EN
      crc_d     = crc_q;
      rx_d      = rx_q;
      cw_d      = cw_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FETCH;
               cnt_d   = '0;
               done_d  = 1'b0;
               err_d   = 1'b0;
`ifdef CFG_LOADER_CRC_EN
               crc_d   = 16'hFFFF;
               rx_d    = '0;
               cw_d    = '0;
`endif
            end
         end
         S_FETCH: begin
            if (abort) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
               done_d  = 1'b1;
            end else if (din_valid && din_ready) begin
               word_d  = din;
               idx_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (abort) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
               done_d  = 1'b1;
            end else begin
               prog_en_d = 1'b1;
               prog_in_d = word_q[0];
               word_d    = word_q >> 1;
               idx_d     = idx_q + 1'b1;
               cnt_d     = bit_cnt + 1'b1;
`ifdef CFG_LOADER_CRC_EN
               crc_d     = crc_step(crc_q, word_q[0]);
               if (cnt_d == LAST_CNT) state_d = S_CRC;
`else
               if (cnt_d == LAST_CNT) state_d = S_DONE;
`endif
               else if (idx_q == LAST_IDX) state_d = S_FETCH;
            end
         end
`ifdef CFG_LOADER_CRC_EN
         S_CRC: begin
            if (abort) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
               done_d  = 1'b1;
            end else if (din_valid && din_ready) begin
               for (int i = 0; i < int'(CRC_WORDS); i++) begin
                  if (cw_q == CW_W'(i)) rx_d[i*WORD_W +: WORD_W] = din;
               end
               cw_d = cw_q + 1'b1;
               if (cw_q == LAST_CW) begin
                  state_d = S_DONE;
                  if (rx_d[15:0] != crc_q) err_d = 1'b1;
               end
            end
         end
`endif
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (state_d == S_DONE) done_d = 1'b1;
`ifdef CFG_LOADER_CRC_EN
      din_ready_d = (state_d == S_FETCH) || (state_d == S_CRC);
      busy_d      = (state_d == S_FETCH) || (state_d == S_SHIFT) || (state_d == S_CRC);
`else
      din_ready_d = (state_d == S_FETCH);
      busy_d      = (state_d == S_FETCH) || (state_d == S_SHIFT);
`endif
   end

endmodule

// File: tb/tb_cfg_bitstream_loader.sv
// Directed bench for cfg_bitstream_loader: a 32-bit chain (default) and a 12-bit chain.
// Define CFG_LOADER_CRC_EN to exercise the CRC trailer path as well.
module tb_cfg_bitstream_loader;

   logic prog_clk = 1'b0;
   logic rst      = 1'b0;
   always #5 prog_clk = ~prog_clk;

   // 32-bit chain instance
   logic        start, abort, din_valid, din_ready, prog_in, prog_en, busy, done, err;
   logic [7:0]  din;
   logic [15:0] bit_cnt;
   // 12-bit chain instance
   logic        start_s, abort_s, din_valid_s, din_ready_s, prog_in_s, prog_en_s, busy_s, done_s, err_s;
   logic [7:0]  din_s;
   logic [15:0] bit_cnt_s;

   cfg_bitstream_loader #(.CHAIN_LEN(32), .WORD_W(8), .CNT_W(16)) u_dut (
      .prog_clk(prog_clk), .rst(rst), .start(start), .abort(abort),
      .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .prog_in(prog_in), .prog_en(prog_en), .busy(busy), .done(done),
      .err(err), .bit_cnt(bit_cnt));

   cfg_bitstream_loader #(.CHAIN_LEN(12), .WORD_W(8), .CNT_W(16)) u_dut_s (
      .prog_clk(prog_clk), .rst(rst), .start(start_s), .abort(abort_s),
      .din(din_s), .din_valid(din_valid_s), .din_ready(din_ready_s),
      .prog_in(prog_in_s), .prog_en(prog_en_s), .busy(busy_s), .done(done_s),
      .err(err_s), .bit_cnt(bit_cnt_s));

`ifdef CFG_LOADER_CRC_EN
   localparam int XW = 2;
`else
   localparam int XW = 0;
`endif

   int errors = 0;
   int checks = 0;

   // Attached chain elements, bit logs and handshake counters.
   logic [31:0] chain;
   logic [11:0] chain_s;
   logic        bitlog   [0:2047];
   logic        bitlog_s [0:2047];
   int en_cnt = 0, en_cnt_s = 0, rdy_cnt = 0, acc_cnt_s = 0;

   always @(posedge prog_clk) if (prog_en)   chain   <= {prog_in, chain[31:1]};
   always @(posedge prog_clk) if (prog_en_s) chain_s <= {prog_in_s, chain_s[11:1]};
   always @(posedge prog_clk) if (din_valid_s && din_ready_s) acc_cnt_s = acc_cnt_s + 1;

   always @(negedge prog_clk) begin
      if (prog_en) begin
         if (en_cnt < 2048) bitlog[en_cnt] = prog_in;
         en_cnt = en_cnt + 1;
      end
      if (prog_en_s) begin
         if (en_cnt_s < 2048) bitlog_s[en_cnt_s] = prog_in_s;
         en_cnt_s = en_cnt_s + 1;
      end
      if (din_ready) rdy_cnt = rdy_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] crc_model(input logic [31:0] d, input int n);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         fb = c[15] ^ d[i];
         c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return c;
   endfunction

   function automatic logic rdy(input bit s12);
      return s12 ? din_ready_s : din_ready;
   endfunction

   task automatic pulse_start(input bit s12);
      @(negedge prog_clk);
      if (s12) start_s = 1'b1; else start = 1'b1;
      @(negedge prog_clk);
      start = 1'b0; start_s = 1'b0;
   endtask

   // Offer one word at a negedge and hold it until accepted (bounded).
   task automatic push(input bit s12, input logic [7:0] w);
      bit ok;
      ok = 1'b0;
      if (s12) begin din_s = w; din_valid_s = 1'b1; end
      else     begin din   = w; din_valid   = 1'b1; end
      for (int i = 0; i < 64; i++) begin
         if (rdy(s12)) begin ok = 1'b1; break; end
         @(negedge prog_clk);
      end
      @(negedge prog_clk);
      if (s12) din_valid_s = 1'b0; else din_valid = 1'b0;
      check("push_accept", 32'(ok), 32'd1);
   endtask

   task automatic wait_done(input bit s12);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 80; i++) begin
         if ((s12 ? done_s : done) === 1'b1) begin ok = 1'b1; break; end
         @(negedge prog_clk);
      end
      check("done_timeout", 32'(ok), 32'd1);
      @(negedge prog_clk);
      #1;
   endtask

   task automatic wait_cnt(input logic [15:0] n);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 80; i++) begin
         if (bit_cnt == n) begin ok = 1'b1; break; end
         @(negedge prog_clk);
      end
      check("cnt_timeout", 32'(ok), 32'd1);
   endtask

   // Full 32-bit session; gap holds din_valid low in the FETCH after word 0
   // and pulses start while busy. flip corrupts one transmitted data bit.
   task automatic load32(input logic [31:0] data, input bit gap, input bit flip);
      logic [31:0] tx;
      bit          ok;
      tx = data ^ (flip ? 32'h0000_0020 : 32'h0);
      pulse_start(1'b0);
      for (int k = 0; k < 4; k++) begin
         push(1'b0, tx[k*8 +: 8]);
         if (gap && k == 0) begin
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
               if (din_ready) begin ok = 1'b1; break; end
               @(negedge prog_clk);
            end
            check("gap_reach_fetch", 32'(ok), 32'd1);
            for (int i = 0; i < 5; i++) begin
               check("gap_ready", 32'(din_ready), 32'd1);
               if (i > 0) check("gap_en_low", 32'(prog_en), 32'd0);
               start = (i == 1);
               @(negedge prog_clk);
            end
            start = 1'b0;
         end
      end
`ifdef CFG_LOADER_CRC_EN
      begin
         logic [15:0] c;
         c = crc_model(data, 32);
         push(1'b0, c[7:0]);
         push(1'b0, c[15:8]);
      end
`endif
      wait_done(1'b0);
   endtask

   int          base_en, base_rdy, base_acc;
   logic [7:0]  first8;
   logic [3:0]  last4;

   initial begin
      start = 0; abort = 0; din = '0; din_valid = 0;
      start_s = 0; abort_s = 0; din_s = '0; din_valid_s = 0;

      // Reset state
      #12;
      check("reset_outs", {15'd0, din_ready, prog_in, prog_en, busy, done, err, bit_cnt[10:0]}, 32'd0);
      check("reset_cnt", 32'(bit_cnt), 32'd0);
      @(negedge prog_clk);
      rst = 1'b1;

      // Back-to-back load of A5,3C,0F,F0
      base_en = en_cnt; base_rdy = rdy_cnt;
      load32(32'hF00F_3CA5, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) first8[i] = bitlog[base_en + i];
      check("b2b_first8", 32'(first8), 32'h0000_00A5);
      check("b2b_en_cnt", 32'(en_cnt - base_en), 32'd32);
      check("b2b_fetches", 32'(rdy_cnt - base_rdy), 32'(4 + XW));
      check("b2b_chain", chain, 32'hF00F_3CA5);
      check("b2b_done", 32'(done), 32'd1);
      check("b2b_err", 32'(err), 32'd0);
      check("b2b_busy", 32'(busy), 32'd0);
      check("b2b_cnt", 32'(bit_cnt), 32'd32);

      // Stalled fetch plus ignored start while busy
      chain = 32'h0;
      base_en = en_cnt;
      load32(32'hF00F_3CA5, 1'b1, 1'b0);
      check("gap_en_cnt", 32'(en_cnt - base_en), 32'd32);
      check("gap_chain", chain, 32'hF00F_3CA5);
      check("gap_done", 32'(done), 32'd1);
      check("gap_err", 32'(err), 32'd0);
      check("gap_cnt", 32'(bit_cnt), 32'd32);

      // 12-bit chain: upper nibble of 0x5A discarded, third word never taken
      base_en = en_cnt_s; base_acc = acc_cnt_s;
      pulse_start(1'b1);
      push(1'b1, 8'hFF);
      push(1'b1, 8'h5A);
`ifdef CFG_LOADER_CRC_EN
      begin
         logic [15:0] c;
         c = crc_model(32'h0000_0AFF, 12);
         push(1'b1, c[7:0]);
         push(1'b1, c[15:8]);
      end
`endif
      din_s = 8'h77; din_valid_s = 1'b1;
      wait_done(1'b1);
      repeat (4) @(negedge prog_clk);
      din_valid_s = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) last4[i] = bitlog_s[base_en + 8 + i];
      check("c12_en_cnt", 32'(en_cnt_s - base_en), 32'd12);
      check("c12_last4", 32'(last4), 32'h0000_000A);
      check("c12_words", 32'(acc_cnt_s - base_acc), 32'(2 + XW));
      check("c12_chain", 32'(chain_s), 32'h0000_0AFF);
      check("c12_cnt", 32'(bit_cnt_s), 32'd12);
      check("c12_done_err", {30'd0, done_s, err_s}, 32'd2);

      // Abort at bit_cnt == 10, then a clean reload
      pulse_start(1'b0);
      push(1'b0, 8'hA5);
      push(1'b0, 8'h3C);
      wait_cnt(16'd10);
      abort = 1'b1;
      @(negedge prog_clk);
      abort = 1'b0;
      check("abort_en", 32'(prog_en), 32'd0);
      check("abort_flags", {28'd0, err, done, busy, din_ready}, 32'h0000_000C);
      check("abort_cnt", 32'(bit_cnt), 32'd10);
      @(negedge prog_clk);
      check("abort_cnt_hold", 32'(bit_cnt), 32'd10);
      chain = 32'h0;
      load32(32'hF00F_3CA5, 1'b0, 1'b0);
      check("reload_flags", {30'd0, done, err}, 32'd2);
      check("reload_chain", chain, 32'hF00F_3CA5);

`ifdef CFG_LOADER_CRC_EN
      // Corrupted data bit against the true CRC
      base_en = en_cnt;
      load32(32'hF00F_3CA5, 1'b0, 1'b1);
      check("crc_bad_flags", {30'd0, done, err}, 32'd3);
      check("crc_bad_en_cnt", 32'(en_cnt - base_en), 32'd32);
`endif

      // Asynchronous reset in the middle of SHIFT
      pulse_start(1'b0);
      push(1'b0, 8'h81);
      wait_cnt(16'd5);
      check("pre_rst_busy", 32'(busy), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("midrst_outs", {25'd0, din_ready, prog_in, prog_en, busy, done, err, 1'b0}, 32'd0);
      check("midrst_cnt", 32'(bit_cnt), 32'd0);
      @(negedge prog_clk);
      rst = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
